time_display_scanner: RTL

//  Downstream display stage for the clock/alarm block.

---
 rtl/time_display_scanner.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/time_display_scanner.sv
// Purpose: scans HH-MM-SS onto an 8-digit active-low 7-segment display with per-field blinking.
// Latency: outputs registered, one cycle behind the scan/snapshot/blink state that produced them.
// Backpressure: none; free-running scan, inputs sampled only at each frame-end edge.
module time_display_scanner #(
  parameter int SCAN_DIV   = 10,
  parameter int GUARD      = 1,
  parameter int BLINK_HALF = 5000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [2:0] blink_mask,
  output logic [7:0] targeten,
  output logic [7:0] targetdisplay
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_V    = CW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ERR   = 8'h86;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [7:0]    snap_h_q, snap_h_d;
  logic [7:0]    snap_m_q, snap_m_d;
  logic [7:0]    snap_s_q, snap_s_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    seg_q, seg_d;

  logic [7:0]    field_v;
  logic          field_blink;
  logic          is_dash;
  logic          is_ones;
  logic [7:0]    bcd;
  logic [7:0]    digit_seg;

  // Tens/ones split by repeated subtraction; only meaningful for v <= 99.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [7:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a} pattern for a decimal digit, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Scan counters, blink timebase and frame-end snapshot of the time fields.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    snap_h_d = snap_h_q;
    snap_m_d = snap_m_q;
    snap_s_d = snap_s_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BW'(1);
    end

    // Latching only here keeps every digit of a frame from the same time value.
    if (idx_q == 3'd7 && cnt_q == CNT_LAST) begin
      snap_h_d = hour;
      snap_m_d = minute;
      snap_s_d = second;
    end
  end

  // Segment pattern for the digit currently selected by idx.
  always_comb begin
    field_v     = 8'd0;
    field_blink = 1'b0;
    is_dash     = 1'b0;
    is_ones     = 1'b0;
    digit_seg   = SEG_BLANK;

    case (idx_q)
      3'd0, 3'd1: begin
        field_v     = snap_s_q;
        field_blink = blink_mask[0];
      end
      3'd3, 3'd4: begin
        field_v     = snap_m_q;
        field_blink = blink_mask[1];
      end
      3'd6, 3'd7: begin
        field_v     = snap_h_q;
        field_blink = blink_mask[2];
      end
      default: is_dash = 1'b1;
    endcase

    is_ones = (idx_q == 3'd0) || (idx_q == 3'd3) || (idx_q == 3'd6);
    bcd     = to_bcd(field_v);

    if (is_dash) begin
      digit_seg = SEG_DASH;
    end else if (phase_q && field_blink) begin
      // Anode stays on while blanked so the duty cycle of other digits is unchanged.
      digit_seg = SEG_BLANK;
    end else if (field_v > 8'd99) begin
      digit_seg = SEG_ERR;
    end else begin
      digit_seg = seg7(is_ones ? bcd[3:0] : bcd[7:4]);
    end
  end

  // Output register inputs: all anodes off during the anti-ghost guard window.
  always_comb begin
    en_d  = 8'hFF;
    seg_d = SEG_BLANK;
    if (cnt_q >= GUARD_V) begin
      en_d  = ~(8'b1 << idx_q);
      seg_d = digit_seg;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      snap_h_q <= 8'd0;
      snap_m_q <= 8'd0;
      snap_s_q <= 8'd0;
      en_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      snap_h_q <= snap_h_d;
      snap_m_q <= snap_m_d;
      snap_s_q <= snap_s_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
    end
  end

  assign targeten      = en_q;
  assign targetdisplay = seg_q;

endmodule
